// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - Wishbone master-side signal bundle for wb_cmd_master
interface wb_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_cab_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cab_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cab_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - queued single-word Wishbone master with err/ack/rty termination
// Optional BUS watchdog (status 11) enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SW        = 4,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [SW-1:0] cmd_sel,
  input  logic [DW-1:0] cmd_dat,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic [1:0]    rsp_status,
  wb_cmd_master_if.master wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int FW = 1 + AW + SW + DW;

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RSP} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fifo_q [DEPTH];
  logic [FW-1:0] fifo_d [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [7:0]    wd_q, wd_d;
`endif

  logic full, empty, push, pop;
  logic [FW-1:0] head;

  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // ready_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = ready_q && !full;
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state_q == RSP) && rsp_ready;
  assign head  = fifo_q[rd_ptr_q[PW-1:0]];

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = (state_q == BUS);
  assign wb.wb_stb_o = (state_q == BUS);
  assign wb.wb_cab_o = 1'b0;

  assign rsp_valid  = (state_q == RSP);
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ready_d  = 1'b1;
    if (push) begin
      fifo_d[wr_ptr_q[PW-1:0]] = {cmd_we, cmd_adr, cmd_sel, cmd_dat};
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    retry_d      = retry_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          {we_d, adr_d, sel_d, dat_d} = head;
          retry_d = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          wd_d    = '0;
`endif
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb.wb_err_i) begin
          rsp_status_d = 2'b01;
          rsp_dat_d    = '0;
          state_d      = RSP;
        end else if (wb.wb_ack_i) begin
          rsp_status_d = 2'b00;
          rsp_dat_d    = we_q ? '0 : wb.wb_dat_i;
          state_d      = RSP;
        end else if (wb.wb_rty_i) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = BACKOFF;
          end else begin
            rsp_status_d = 2'b10;
            rsp_dat_d    = '0;
            state_d      = RSP;
          end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        end else if (wd_q == 8'd254) begin
          // this is the 255th unterminated BUS cycle
          rsp_status_d = 2'b11;
          rsp_dat_d    = '0;
          state_d      = RSP;
        end else begin
          wd_d = wd_q + 8'd1;
`endif
        end
      end
      BACKOFF: begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = BUS;
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ready_q      <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      retry_q      <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ready_q      <= ready_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      retry_q      <= retry_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master with in-order response model
module tb_wb_cmd_master;
  localparam int DW = 32, AW = 32, SW = 4, DEPTH = 4, MAX_RETRY = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_we    = 1'b0;
  logic [AW-1:0] cmd_adr   = '0;
  logic [SW-1:0] cmd_sel   = '0;
  logic [DW-1:0] cmd_dat   = '0;
  logic          rsp_ready = 1'b0;
  logic          cmd_ready, rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic [1:0]    rsp_status;

  wb_cmd_master_if #(.AW(AW), .DW(DW), .SW(SW)) wb ();

  wb_cmd_master #(.DW(DW), .AW(AW), .SW(SW), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb(wb)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc_n = 0;
  initial forever begin @(posedge clk); cyc_n++; end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // ---------------- reference model: ordered transactions with expected results
  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
    logic [1:0]    st;
    logic [DW-1:0] rd;
  } txn_t;
  txn_t expq[$];
  logic [DW-1:0] mmem [bit [AW-1:0]];
  logic [DW-1:0] smem [bit [AW-1:0]];

  // slave behaviour knobs
  int            slv_wait   = 0;
  int            slv_rty    = 0;
  int            rty_given  = 0;
  logic          slv_silent = 1'b0;
  logic [AW-1:0] err_adr    = '1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic model_push(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                            input logic [DW-1:0] dat);
    txn_t t;
    logic [DW-1:0] cur;
    t.we = we; t.adr = adr; t.sel = sel; t.dat = dat; t.rd = '0;
    cur = mmem.exists(adr) ? mmem[adr] : init_word(adr);
    if (slv_silent)              t.st = 2'b11;
    else if (adr == err_adr)     t.st = 2'b01;
    else if (slv_rty > MAX_RETRY) t.st = 2'b10;
    else begin
      t.st = 2'b00;
      if (we) mmem[adr] = merge(cur, dat, sel);
      else    t.rd = cur;
    end
    expq.push_back(t);
  endtask

  // ---------------- Wishbone slave
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] cur;
    int waitcnt;
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wb.wb_dat_i = '0;
    waitcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst || !(wb.wb_cyc_o && wb.wb_stb_o)) begin
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
        waitcnt = 0;
      end else if (!(wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i)) begin
        if (waitcnt < slv_wait) waitcnt++;
        else if (!slv_silent) begin
          a = wb.wb_adr_o;
          cur = smem.exists(a) ? smem[a] : init_word(a);
          if (a == err_adr) begin
            wb.wb_err_i = 1'b1; wb.wb_ack_i = 1'b1; wb.wb_dat_i = '1;
          end else if (rty_given < slv_rty) begin
            wb.wb_rty_i = 1'b1;
            rty_given++;
            if (rty_given == MAX_RETRY + 1) rty_given = 0;
          end else begin
            wb.wb_ack_i = 1'b1;
            rty_given = 0;
            if (wb.wb_we_o) begin
              smem[a] = merge(cur, wb.wb_dat_o, wb.wb_sel_o);
              wb.wb_dat_i = 32'hCAFE_F00D;
            end else wb.wb_dat_i = cur;
          end
        end
      end
    end
  end

  // ---------------- compare process and bus monitor
  int   hi_cnt, rises, first_hi, last_hi, vld_cnt, hs_edge;
  logic prev_cyc = 1'b0;
  task automatic reset_mon();
    hi_cnt = 0; rises = 0; first_hi = -1; last_hi = -1; vld_cnt = 0;
  endtask

  initial begin
    logic          pv, pr;
    logic [DW-1:0] pd;
    logic [1:0]    ps;
    txn_t          t;
    pv = 1'b0; pr = 1'b0; pd = '0; ps = '0; hs_edge = -1;
    reset_mon();
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pv = 1'b0; prev_cyc = 1'b0;
      end else begin
        check("cab_zero", wb.wb_cab_o, 1'b0);
        if (wb.wb_cyc_o) begin
          hi_cnt++;
          if (!prev_cyc) rises++;
          if (first_hi < 0) first_hi = cyc_n;
          last_hi = cyc_n;
          if (expq.size() == 0) fail("cyc_without_command");
          else begin
            t = expq[0];
            check("stb_with_cyc", wb.wb_stb_o, 1'b1);
            check("bus_adr", wb.wb_adr_o, t.adr);
            check("bus_we", wb.wb_we_o, t.we);
            check("bus_sel", wb.wb_sel_o, t.sel);
            check("bus_dat", wb.wb_dat_o, t.dat);
          end
        end
        prev_cyc = wb.wb_cyc_o;
        if (rsp_valid) vld_cnt++;
        if (pv && !pr && rsp_valid) begin
          check("rsp_dat_stable", rsp_dat, pd);
          check("rsp_status_stable", rsp_status, ps);
        end
        if (rsp_valid && rsp_ready) begin
          if (expq.size() == 0) fail("unexpected_response");
          else begin
            t = expq.pop_front();
            check("rsp_status", rsp_status, t.st);
            check("rsp_dat", rsp_dat, t.rd);
          end
          if (hs_edge < 0) hs_edge = cyc_n + 1;
        end
        pv = rsp_valid; pr = rsp_ready; pd = rsp_dat; ps = rsp_status;
      end
    end
  end

  // ---------------- stimulus helpers
  int n_acc = 0, last_acc = 0;

  task automatic push(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                      input logic [DW-1:0] dat);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) fail("push_timeout");
    else begin
      @(posedge clk);
      #1;
      last_acc = cyc_n;
      n_acc++;
      model_push(we, adr, sel, dat);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (!rsp_valid && n < lim) begin @(negedge clk); n++; end
    if (!rsp_valid) fail("wait_rsp_valid_timeout");
  endtask

  task automatic take_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((expq.size() != 0 || wb.wb_cyc_o || rsp_valid) && n < lim) begin @(negedge clk); n++; end
    if (expq.size() != 0 || wb.wb_cyc_o || rsp_valid) fail("wait_idle_timeout");
  endtask

  // ---------------- directed tests
  initial begin
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_cyc", wb.wb_cyc_o, 1'b0);
    check("rst_stb", wb.wb_stb_o, 1'b0);
    check("rst_adr", wb.wb_adr_o, 32'h0);
    check("rst_rsp_status", rsp_status, 2'b00);
    repeat (2) @(posedge clk);
    #1 check("rst_cmd_ready_held", cmd_ready, 1'b0);
    @(negedge clk); #1 rst = 1'b1;
    #1 check("rel_cmd_ready_before_edge", cmd_ready, 1'b0);
    @(posedge clk); #1 check("rel_cmd_ready_after_edge", cmd_ready, 1'b1);

    // write then read, zero wait states, with latency pins
    push(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    check("lat_cyc_at_N", wb.wb_cyc_o, 1'b0);
    @(posedge clk); #1 check("lat_cyc_at_N1", wb.wb_cyc_o, 1'b1);
    check("lat_rsp_at_N1", rsp_valid, 1'b0);
    @(posedge clk); #1 check("lat_rsp_at_N2", rsp_valid, 1'b1);
    check("wr_status_lit", rsp_status, 2'b00);
    check("wr_dat_lit", rsp_dat, 32'h0);
    take_rsp();
    push(1'b0, 32'h10, 4'hF, 32'h0);
    wait_valid(20);
    check("rd_status_lit", rsp_status, 2'b00);
    check("rd_dat_lit", rsp_dat, 32'hDEAD_BEEF);
    take_rsp();
    wait_idle(20);

    // wait states and partial byte write
    slv_wait = 2; rsp_ready = 1'b1;
    push(1'b0, 32'h44, 4'hF, 32'h0);
    push(1'b1, 32'h48, 4'h3, 32'h1122_3344);
    push(1'b0, 32'h48, 4'hF, 32'h0);
    wait_idle(100);
    slv_wait = 0; rsp_ready = 1'b0;

    // FIFO full with responses blocked
    n_acc = 0; hs_edge = -1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push(i[0], 32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
          if (i == 3) check("full_after_4", cmd_ready, 1'b0);
        end
      end
      begin
        repeat (12) @(negedge clk);
        check("accepted_while_blocked", 32'(n_acc), 32'd4);
        rsp_ready = 1'b1;
      end
    join
    check("fifth_after_handshake", 32'(last_acc), 32'(hs_edge + 1));
    wait_idle(100);

    // retry: three rty then ack
    reset_mon(); slv_rty = 3;
    push(1'b0, 32'h30, 4'hF, 32'h0);
    wait_idle(100);
    check("rty3_bus_cycles", 32'(rises), 32'd4);
    check("rty3_hi_cycles", 32'(hi_cnt), 32'd4);
    check("rty3_span", 32'(last_hi - first_hi + 1), 32'd7);
    // retry exhausted
    reset_mon(); slv_rty = 4; rsp_ready = 1'b0;
    push(1'b1, 32'h30, 4'hF, 32'h0BAD_0BAD);
    wait_valid(100);
    check("rty4_status_lit", rsp_status, 2'b10);
    check("rty4_dat_lit", rsp_dat, 32'h0);
    check("rty4_bus_cycles", 32'(rises), 32'd4);
    check("rty4_span", 32'(last_hi - first_hi + 1), 32'd7);
    take_rsp();
    slv_rty = 0;
    push(1'b0, 32'h30, 4'hF, 32'h0);
    wait_valid(20);
    check("rty4_no_write_lit", rsp_dat, 32'h5A5A_0030);
    take_rsp();
    wait_idle(20);

    // err and ack together, then a normal command
    err_adr = 32'h20;
    push(1'b0, 32'h20, 4'hF, 32'h0);
    push(1'b1, 32'h24, 4'hF, 32'h7777_8888);
    wait_valid(20);
    check("err_status_lit", rsp_status, 2'b01);
    check("err_dat_lit", rsp_dat, 32'h0);
    take_rsp();
    wait_valid(20);
    check("after_err_status_lit", rsp_status, 2'b00);
    take_rsp();
    wait_idle(20);
    err_adr = '1;

    // reset in the middle of a bus cycle with commands queued
    slv_wait = 50;
    push(1'b0, 32'h50, 4'hF, 32'h0);
    push(1'b0, 32'h54, 4'hF, 32'h0);
    push(1'b0, 32'h58, 4'hF, 32'h0);
    begin
      int n;
      n = 0;
      while (!wb.wb_cyc_o && n < 20) begin @(negedge clk); n++; end
    end
    check("midrst_cyc_before", wb.wb_cyc_o, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("midrst_cyc", wb.wb_cyc_o, 1'b0);
    check("midrst_stb", wb.wb_stb_o, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    expq.delete(); rty_given = 0; slv_wait = 0;
    repeat (2) @(posedge clk);
    #1 check("midrst_cmd_ready_held", cmd_ready, 1'b0);
    @(negedge clk); #1 rst = 1'b1;
    #1 check("midrel_cmd_ready_before_edge", cmd_ready, 1'b0);
    @(posedge clk); #1 check("midrel_cmd_ready_after_edge", cmd_ready, 1'b1);
    reset_mon(); rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_bus_after", 32'(hi_cnt), 32'd0);
    check("midrst_no_rsp_after", 32'(vld_cnt), 32'd0);

    // silent slave
    slv_silent = 1'b1; reset_mon();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    rsp_ready = 1'b0;
    push(1'b0, 32'h60, 4'hF, 32'h0);
    wait_valid(400);
    check("timeout_status_lit", rsp_status, 2'b11);
    check("timeout_dat_lit", rsp_dat, 32'h0);
    check("timeout_bus_cycles", 32'(hi_cnt), 32'd255);
    take_rsp();
    slv_silent = 1'b0;
    wait_idle(20);
`else
    push(1'b0, 32'h60, 4'hF, 32'h0);
    repeat (1005) @(negedge clk);
    check("no_timeout_cyc_high", wb.wb_cyc_o, 1'b1);
    check("no_timeout_long", (hi_cnt > 1000), 1'b1);
    check("no_timeout_no_rsp", 32'(vld_cnt), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    expq.delete(); slv_silent = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end
endmodule
